data_mem_responder: RTL and testbench

- Memory-side end of the core's word-addressed data-RAM interface: accepts the word address, write data, byte-lane write enables and read enable produced by the load/store unit's first stage.
- Services each request over a single-outstanding req/ack bus to backing memory (BRAM controller, MMIO fabric).
- Returns the raw 32-bit word consumed by the load-alignment stage, and stalls the pipeline while a transaction is pending.
- Adds a timeout watchdog that terminates unanswered transactions with a bus error.

---
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-RAM responder: turns LSU word requests into single-outstanding bus req/ack transactions, 3-cycle minimum occupancy.
// Stalls the pipeline from request acceptance until the DONE cycle; unanswered transactions abort with a bus error.
module data_mem_responder #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [29:0] ram_addr_i,
    input  logic [31:0] ram_wdata_i,
    input  logic [3:0]  ram_wen_i,
    input  logic        ram_ren_i,
    output logic [31:0] ram_data_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             req;

    assign req = (ram_wen_i != 4'b0000) || ram_ren_i;

    // Reset gates the IDLE term so stall drops immediately even with a request still on the inputs.
    assign stall_o = (state == S_BUSY) || ((state == S_IDLE) && req && !rst_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ram_data_o  <= 32'h0;
            bus_err_o   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        bus_req_o   <= 1'b1;
                        bus_addr_o  <= {ram_addr_i, 2'b00};
                        bus_wdata_o <= ram_wdata_i;
                        cnt         <= '0;
                        state       <= S_BUSY;
                        // A write takes precedence over a simultaneous read.
                        if (ram_wen_i != 4'b0000) begin
                            bus_we_o <= 1'b1;
                            bus_be_o <= ram_wen_i;
                        end else begin
                            bus_we_o <= 1'b0;
                            bus_be_o <= 4'b1111;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            ram_data_o <= bus_rdata_i;
                        end
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        if (!bus_we_o) begin
                            ram_data_o <= 32'h0;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    bus_err_o <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: vector table of bus transactions against a small memory model, plus timeout and reset sequences.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT (default timeout)
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wen;
    logic        ram_ren;
    logic [31:0] ram_data;
    logic        stall, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    // Short-timeout DUT
    logic [29:0] t_addr;
    logic [31:0] t_wdata_in;
    logic [3:0]  t_wen;
    logic        t_ren;
    logic [31:0] t_data;
    logic        t_stall, t_err, t_req, t_we;
    logic [31:0] t_bus_addr, t_bus_wdata;
    logic [3:0]  t_be;
    logic        t_ack;
    logic [31:0] t_rdata;

    data_mem_responder u_dut (
        .clk_i(clk), .rst_i(rst),
        .ram_addr_i(ram_addr), .ram_wdata_i(ram_wdata), .ram_wen_i(ram_wen), .ram_ren_i(ram_ren),
        .ram_data_o(ram_data), .stall_o(stall), .bus_err_o(bus_err),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
        .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
    );

    data_mem_responder #(.TIMEOUT_CYCLES(4), .CNT_W(16)) u_to (
        .clk_i(clk), .rst_i(rst),
        .ram_addr_i(t_addr), .ram_wdata_i(t_wdata_in), .ram_wen_i(t_wen), .ram_ren_i(t_ren),
        .ram_data_o(t_data), .stall_o(t_stall), .bus_err_o(t_err),
        .bus_req_o(t_req), .bus_we_o(t_we), .bus_addr_o(t_bus_addr), .bus_be_o(t_be),
        .bus_wdata_o(t_bus_wdata), .bus_ack_i(t_ack), .bus_rdata_i(t_rdata)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        logic [3:0]  wen;
        logic        ren;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        int          e_stall;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with request inputs cleared.
    task automatic do_txn(input vec_t v, input string tag);
        int          stall_n;
        int          req_n;
        logic        done;
        logic        stable;
        logic [31:0] d_data;
        logic [31:0] mask;
        logic        d_err;
        logic        d_req;
        stall_n = 0; req_n = 0; done = 1'b0; stable = 1'b1;
        d_data = 32'h0; d_err = 1'b0; d_req = 1'b0;
        ram_wen = v.wen; ram_ren = v.ren; ram_addr = v.addr; ram_wdata = v.wdata;
        bus_ack = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (!stall && c > 0) begin
                done   = 1'b1;
                d_data = ram_data;
                d_err  = bus_err;
                d_req  = bus_req;
            end else begin
                if (stall) stall_n++;
                if (bus_req) begin
                    if (bus_addr !== v.e_addr || bus_be !== v.e_be || bus_we !== v.e_we ||
                        (v.e_we && bus_wdata !== v.wdata))
                        stable = 1'b0;
                    if (req_n == v.delay) begin
                        bus_ack   = 1'b1;
                        bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
                        if (bus_we) begin
                            mask = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
                            mem[bus_addr] = (bus_rdata & ~mask) | (bus_wdata & mask);
                        end
                    end
                    req_n++;
                end
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_rdata = 32'hDEADBEEF;
            end
        end
        chk({tag, "_completed"}, {31'h0, done}, 32'h1);
        chk({tag, "_stall_cycles"}, stall_n, v.e_stall);
        chk({tag, "_req_cycles"}, req_n, v.delay + 1);
        chk({tag, "_bus_fields"}, {31'h0, stable}, 32'h1);
        chk({tag, "_ram_data"}, d_data, v.e_data);
        chk({tag, "_err_done"}, {31'h0, d_err}, 32'h0);
        chk({tag, "_req_done"}, {31'h0, d_req}, 32'h0);
        @(negedge clk);
        ram_wen = 4'b0; ram_ren = 1'b0; ram_addr = 30'h0; ram_wdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int rq, er, st, done_at;
        vec_t vr;

        //         wen      ren   addr        wdata         dly  e_addr        e_be     e_we  stall e_data
        vecs[0] = '{4'b0100, 1'b0, 30'h100, 32'h00AB0000, 0, 32'h00000400, 4'b0100, 1'b1, 2, 32'h00000000};
        vecs[1] = '{4'b0000, 1'b1, 30'h003, 32'h00000000, 0, 32'h0000000C, 4'b1111, 1'b0, 2, 32'hCAFEF00D};
        vecs[2] = '{4'b0000, 1'b1, 30'h010, 32'h00000000, 5, 32'h00000040, 4'b1111, 1'b0, 7, 32'h5A5A1234};
        vecs[3] = '{4'b1111, 1'b0, 30'h008, 32'h12345678, 0, 32'h00000020, 4'b1111, 1'b1, 2, 32'h5A5A1234};
        vecs[4] = '{4'b0000, 1'b1, 30'h008, 32'h00000000, 1, 32'h00000020, 4'b1111, 1'b0, 3, 32'h12345678};
        vecs[5] = '{4'b0011, 1'b1, 30'h010, 32'h0000BEEF, 2, 32'h00000040, 4'b0011, 1'b1, 4, 32'h12345678};
        vecs[6] = '{4'b0000, 1'b1, 30'h010, 32'h00000000, 0, 32'h00000040, 4'b1111, 1'b0, 2, 32'h5A5ABEEF};

        mem[32'h0000000C] = 32'hCAFEF00D;
        mem[32'h00000040] = 32'h5A5A1234;

        rst = 1'b1;
        ram_addr = 30'h0; ram_wdata = 32'h0; ram_wen = 4'b0; ram_ren = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
        t_addr = 30'h0; t_wdata_in = 32'h0; t_wen = 4'b0; t_ren = 1'b0;
        t_ack = 1'b0; t_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ram_data", ram_data, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be_we_err", {26'h0, bus_be, bus_we, bus_err}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_t_outputs", {27'h0, t_req, t_we, t_err, t_stall, |t_be}, 32'h0);
        chk("rst_t_data", t_data | t_bus_addr | t_bus_wdata, 32'h0);

        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Short-timeout DUT: a good read first so the abort visibly clears ram_data.
        t_ren = 1'b1; t_addr = 30'h5;
        @(negedge clk);
        #1;
        chk("to_read_req", {31'h0, t_req}, 32'h1);
        chk("to_read_addr", t_bus_addr, 32'h00000014);
        t_ack = 1'b1; t_rdata = 32'h11112222;
        @(negedge clk);
        t_ack = 1'b0; t_rdata = 32'h0;
        #1;
        chk("to_read_data", t_data, 32'h11112222);
        chk("to_read_stall_done", {31'h0, t_stall}, 32'h0);
        @(negedge clk);
        t_ren = 1'b0;
        @(negedge clk);

        t_ren = 1'b1; t_addr = 30'h6;
        rq = 0; er = 0; st = 0; done_at = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (t_req) begin
                rq++;
                chk("to_bus_addr_be", {t_bus_addr[27:0], t_be}, {28'h0000018, 4'b1111});
            end
            if (t_err) er++;
            if (t_stall) st++;
            if (!t_stall && c > 0 && done_at < 0) begin
                done_at = c;
                chk("to_data_cleared", t_data, 32'h0);
            end
            @(negedge clk);
            if (done_at >= 0) t_ren = 1'b0;
        end
        chk("to_req_cycles", rq, 4);
        chk("to_err_pulses", er, 1);
        chk("to_stall_cycles", st, 5);
        chk("to_done_cycle", done_at, 5);

        t_ack = 1'b1; t_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        t_ack = 1'b0;
        #1;
        chk("late_ack_data", t_data, 32'h0);
        chk("late_ack_ctrl", {29'h0, t_req, t_stall, t_err}, 32'h0);

        // Asynchronous reset in the middle of a waiting read.
        @(negedge clk);
        ram_ren = 1'b1; ram_addr = 30'h10;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_busy_req", {31'h0, bus_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_req", {31'h0, bus_req}, 32'h0);
        chk("arst_stall", {31'h0, stall}, 32'h0);
        chk("arst_ram_data", ram_data, 32'h0);
        chk("arst_bus_addr", bus_addr, 32'h0);
        chk("arst_be_we_err", {26'h0, bus_be, bus_we, bus_err}, 32'h0);
        ram_ren = 1'b0; ram_addr = 30'h0;
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h77777777;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
        #1;
        chk("post_rst_stale_data", ram_data, 32'h0);
        chk("post_rst_stale_ctrl", {30'h0, bus_req, stall}, 32'h0);

        @(negedge clk);
        vr = '{4'b0000, 1'b1, 30'h010, 32'h0, 2, 32'h00000040, 4'b1111, 1'b0, 4, 32'h5A5ABEEF};
        do_txn(vr, "post_rst_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
